// File: rtl/byte4to3_pkg.sv
// rtl/byte4to3_pkg.sv - shared state encoding and byte layout for the 32-to-24 unpacker
package pix_pkg;
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_t;

   localparam int G_OFS          = 0;
   localparam int B_OFS          = 1;
   localparam int R_OFS          = 2;
   localparam int BYTES_PER_PIX  = 3;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte4to3_if.sv
// rtl/byte4to3_if.sv - word-in / pixel-out valid-ready bundle for byte4to3
interface byte4to3_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_rgb;
   logic        out_eol;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_rgb, out_eol
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_rgb, out_eol
   );
endinterface

// File: rtl/byte4to3_outreg.sv
// rtl/byte4to3_outreg.sv - single-entry valid/ready output register
module byte4to3_outreg #(
   parameter int W = 25
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] q,
   output logic         slot_free
);

   assign slot_free = !valid || ready;

   // Payload is frozen under backpressure; a load wins over a drain so consume+produce has no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/byte4to3.sv
// rtl/byte4to3.sv - 32-bit word to 24-bit pixel unpacker with line realignment; optional BYTE4TO3_PAD_CHECK_EN
module byte4to3
   import pix_pkg::*;
#(
   parameter int LINE_PIXELS = 1920,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic rst_n,
   byte4to3_if.slave bus
`ifdef BYTE4TO3_PAD_CHECK_EN
   ,
   output logic pad_err
`endif
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] pix_cnt, cnt_nxt;
   logic [7:0]       h     [BYTES_PER_PIX];
   logic [7:0]       h_nxt [BYTES_PER_PIX];
   logic [7:0]       b     [BYTES_PER_WORD];
   logic [7:0]       px    [BYTES_PER_PIX];
   logic             slot_free;
   logic             accept;
   logic             produce;
   logic             line_end;
   logic [24:0]      pix_word;
   logic [24:0]      out_q;

   for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_bytes
      assign b[k] = bus.in_data[8*k +: 8];
   end

   assign bus.in_ready = slot_free && (state != S3);
   assign accept       = bus.in_valid && bus.in_ready;
   assign pix_word     = {line_end, px[R_OFS], px[B_OFS], px[G_OFS]};

   // Byte steering: pick G,B,R from residue then word, keep the leftover bytes for the next pixel.
   always_comb begin
      state_nxt = state;
      h_nxt     = h;
      px        = '{default: 8'h00};
      produce   = 1'b0;
      unique case (state)
         S0: if (accept) begin
            produce    = 1'b1;
            px[G_OFS]  = b[0];
            px[B_OFS]  = b[1];
            px[R_OFS]  = b[2];
            h_nxt[0]   = b[3];
            state_nxt  = S1;
         end
         S1: if (accept) begin
            produce    = 1'b1;
            px[G_OFS]  = h[0];
            px[B_OFS]  = b[0];
            px[R_OFS]  = b[1];
            h_nxt[0]   = b[2];
            h_nxt[1]   = b[3];
            state_nxt  = S2;
         end
         S2: if (accept) begin
            produce    = 1'b1;
            px[G_OFS]  = h[0];
            px[B_OFS]  = h[1];
            px[R_OFS]  = b[0];
            h_nxt[0]   = b[1];
            h_nxt[1]   = b[2];
            h_nxt[2]   = b[3];
            state_nxt  = S3;
         end
         S3: if (slot_free) begin
            produce    = 1'b1;
            px[G_OFS]  = h[0];
            px[B_OFS]  = h[1];
            px[R_OFS]  = h[2];
            state_nxt  = S0;
         end
      endcase
      line_end = produce && (pix_cnt == CNT_W'(LINE_PIXELS - 1));
      // Last pixel of a line drops all residue so the next line starts word-aligned.
      if (line_end) state_nxt = S0;
      if (line_end)     cnt_nxt = '0;
      else if (produce) cnt_nxt = pix_cnt + CNT_W'(1);
      else              cnt_nxt = pix_cnt;
   end

   // Steering state, pixel position within the line and residual bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S0;
         pix_cnt <= '0;
         h[0]    <= 8'h00;
         h[1]    <= 8'h00;
         h[2]    <= 8'h00;
      end else begin
         state   <= state_nxt;
         pix_cnt <= cnt_nxt;
         h       <= h_nxt;
      end
   end

   byte4to3_outreg #(.W(25)) u_outreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (produce),
      .data      (pix_word),
      .ready     (bus.out_ready),
      .valid     (bus.out_valid),
      .q         (out_q),
      .slot_free (slot_free)
   );

   assign bus.out_rgb = out_q[23:0];
   assign bus.out_eol = out_q[24];

`ifdef BYTE4TO3_PAD_CHECK_EN
   logic disc_nz;

   // Bytes thrown away at line end are the ones this production would otherwise have kept.
   always_comb begin
      disc_nz = 1'b0;
      unique case (state)
         S0: disc_nz = |b[3];
         S1: disc_nz = |{b[2], b[3]};
         S2: disc_nz = |{b[1], b[2], b[3]};
         S3: disc_nz = 1'b0;
      endcase
   end

   // Sticky flag: any nonzero padding byte seen at a line end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pad_err <= 1'b0;
      else if (line_end && disc_nz) pad_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_byte4to3.sv
// tb/tb_byte4to3.sv - self-checking bench for byte4to3 (line lengths 8, 5 and 7)
module tb_byte4to3;

   typedef struct packed {
      logic        eol;
      logic [23:0] rgb;
   } pix_t;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        rdy;
      logic        ov;
      logic [23:0] rgb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n     [3];
   logic        in_valid  [3];
   logic [31:0] in_data   [3];
   logic        out_ready [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic [23:0] out_rgb   [3];
   logic        out_eol   [3];
   logic        pad_err   [3];

   int          lp_tab [3] = '{8, 5, 7};
   int          n_vec;
   int          n_fail;
   int          cur;

   pix_t        exp_q  [$];
   pix_t        got_q  [$];
   logic [7:0]  mbytes [$];
   logic [31:0] stim_q [$];
   int          mcnt;
   logic        exp_pad;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LP = (g == 0) ? 8 : ((g == 1) ? 5 : 7);
      byte4to3_if bif ();
      assign bif.in_valid  = in_valid[g];
      assign bif.in_data   = in_data[g];
      assign bif.out_ready = out_ready[g];
      assign in_ready[g]   = bif.in_ready;
      assign out_valid[g]  = bif.out_valid;
      assign out_rgb[g]    = bif.out_rgb;
      assign out_eol[g]    = bif.out_eol;
`ifndef BYTE4TO3_PAD_CHECK_EN
      assign pad_err[g]    = 1'b0;
`endif
      byte4to3 #(.LINE_PIXELS(LP), .CNT_W(16)) dut (
         .clk   (clk),
         .rst_n (rst_n[g]),
         .bus   (bif.slave)
`ifdef BYTE4TO3_PAD_CHECK_EN
         ,
         .pad_err (pad_err[g])
`endif
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Byte-stream reference: accepted words feed a byte FIFO, every 3 bytes make a pixel.
   task automatic model_word(input logic [31:0] w);
      logic [7:0] g, bb, r;
      pix_t       p;
      for (int k = 0; k < 4; k++) mbytes.push_back(w[8*k +: 8]);
      while (mbytes.size() >= 3) begin
         g  = mbytes.pop_front();
         bb = mbytes.pop_front();
         r  = mbytes.pop_front();
         mcnt++;
         p.rgb = {r, bb, g};
         p.eol = (mcnt == lp_tab[cur]);
         exp_q.push_back(p);
         if (p.eol) begin
            foreach (mbytes[i]) if (mbytes[i] != 8'h00) exp_pad = 1'b1;
            mbytes.delete();
            mcnt = 0;
         end
      end
   endtask

   // Scoreboard: push expectations on accepted words, compare on consumed pixels.
   always @(negedge clk) begin
      pix_t p, e;
      if (!rst_n[cur]) begin
         exp_q.delete();
         mbytes.delete();
         mcnt    = 0;
         exp_pad = 1'b0;
      end else begin
         if (in_valid[cur] && in_ready[cur]) model_word(in_data[cur]);
         if (out_valid[cur] && out_ready[cur]) begin
            p.rgb = out_rgb[cur];
            p.eol = out_eol[cur];
            got_q.push_back(p);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL sb_extra_pixel: got 0x%0h, expected no pixel", p);
            end else begin
               e = exp_q.pop_front();
               check("sb_pixel", 32'(p), 32'(e));
            end
         end
      end
   end

   task automatic do_reset(input int d);
      cur          = d;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      rst_n[d]     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n[d]  = 1'b1;
      got_q.delete();
   endtask

   task automatic run(input int pv, input int pr, input int want_pix, input int budget);
      int c = 0;
      while ((stim_q.size() > 0 || got_q.size() < want_pix) && c < budget) begin
         @(posedge clk);
         #1;
         in_valid[cur]  = (stim_q.size() > 0) && ($urandom_range(99) < pv);
         in_data[cur]   = (stim_q.size() > 0) ? stim_q[0] : 32'h0;
         out_ready[cur] = ($urandom_range(99) < pr);
         @(negedge clk);
         if (in_valid[cur] && in_ready[cur]) void'(stim_q.pop_front());
         c++;
      end
      check("run_timeout", 32'(c >= budget), 32'd0);
      @(posedge clk);
      #1;
      in_valid[cur]  = 1'b0;
      out_ready[cur] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      logic [31:0] bw  [3];
      logic [31:0] w;
      int          idx;

      n_vec = 0;
      n_fail = 0;
      cur = 0;
      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 32'h0; out_ready[d] = 1'b1;
      end
      repeat (3) @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         check("rst_out_valid", 32'(out_valid[d]), 32'd0);
         check("rst_out_rgb", 32'(out_rgb[d]), 32'd0);
         check("rst_out_eol", 32'(out_eol[d]), 32'd0);
         check("rst_pad_err", 32'(pad_err[d]), 32'd0);
      end
      #1;
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("rst_in_ready", 32'(in_ready[d]), 32'd1);

      // Basic unpack, cycle-exact (LINE_PIXELS=8)
      tbl[0] = '{1'b1, 32'h04030201, 1'b1, 1'b0, 24'h000000};
      tbl[1] = '{1'b1, 32'h08070605, 1'b1, 1'b1, 24'h030201};
      tbl[2] = '{1'b1, 32'h0C0B0A09, 1'b1, 1'b1, 24'h060504};
      tbl[3] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 24'h090807};
      tbl[4] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 24'h0C0B0A};
      tbl[5] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 24'h000000};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         in_valid[0] = tbl[i].v;
         in_data[0]  = tbl[i].d;
         @(negedge clk);
         check("basic_in_ready", 32'(in_ready[0]), 32'(tbl[i].rdy));
         check("basic_out_valid", 32'(out_valid[0]), 32'(tbl[i].ov));
         if (tbl[i].ov) check("basic_out_rgb", 32'(out_rgb[0]), 32'(tbl[i].rgb));
      end
      check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: consumer stalls 5 cycles after the first pixel
      do_reset(0);
      bw[0] = 32'h04030201; bw[1] = 32'h08070605; bw[2] = 32'h0C0B0A09;
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk);
         #1;
         in_valid[0]  = (idx < 3);
         in_data[0]   = (idx < 3) ? bw[idx] : 32'h0;
         out_ready[0] = !(c >= 1 && c <= 5);
         @(negedge clk);
         if (c >= 1 && c <= 5) begin
            check("bp_out_valid", 32'(out_valid[0]), 32'd1);
            check("bp_out_rgb", 32'(out_rgb[0]), 32'h030201);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
         end
         if (in_valid[0] && in_ready[0]) idx++;
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      check("bp_pixel_count", 32'(got_q.size()), 32'd4);
      check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while in S2 with a pixel pending
      do_reset(0);
      @(posedge clk); #1; in_valid[0] = 1'b1; in_data[0] = 32'h04030201;
      @(posedge clk); #1; in_data[0] = 32'h08070605;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      check("rstmid_pre_valid", 32'(out_valid[0]), 32'd1);
      #2 rst_n[0] = 1'b0;
      #1;
      check("rstmid_out_valid", 32'(out_valid[0]), 32'd0);
      check("rstmid_out_rgb", 32'(out_rgb[0]), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n[0] = 1'b1;
      got_q.delete();
      stim_q.push_back(32'h04030201);
      run(100, 100, 1, 50);
      check("rstmid_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) check("rstmid_first_pixel", 32'(got_q[0]), {8'h0, 1'b0, 24'h030201});
      check("rstmid_sb_empty", 32'(exp_q.size()), 32'd0);

      // Line end and realignment (LINE_PIXELS=5)
      do_reset(1);
      stim_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h00000D0C, 32'h11100F0E};
      run(100, 100, 6, 100);
      check("eol_count", 32'(got_q.size()), 32'd6);
      if (got_q.size() >= 6) begin
         check("eol_fifth_pixel", 32'(got_q[4]), {8'h0, 1'b1, 24'h000D0C});
         check("eol_realigned", 32'(got_q[5]), {8'h0, 1'b0, 24'h100F0E});
      end
      check("eol_sb_empty", 32'(exp_q.size()), 32'd0);
      check("eol_pad_err_clean", 32'(pad_err[1]), 32'd0);

`ifdef BYTE4TO3_PAD_CHECK_EN
      // Nonzero padding at line end sets the sticky flag
      do_reset(1);
      stim_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'hAA000D0C};
      run(100, 100, 5, 100);
      check("pad_err_model", 32'(pad_err[1]), 32'(exp_pad));
      repeat (4) @(posedge clk);
      #1;
      check("pad_err_sticky", 32'(pad_err[1]), 32'd1);
      do_reset(1);
      stim_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h00000D0C};
      run(100, 100, 5, 100);
      check("pad_err_zero_pad", 32'(pad_err[1]), 32'd0);
`endif

      // Random valid/ready over 3 lines (LINE_PIXELS=7)
      do_reset(2);
      for (int ln = 0; ln < 3; ln++) begin
         for (int k = 0; k < 6; k++) begin
            w = $urandom;
            if (k == 5) w = w & 32'h000000FF;
            stim_q.push_back(w);
         end
      end
      run(70, 70, 21, 3000);
      check("rand_count", 32'(got_q.size()), 32'd21);
      foreach (got_q[i]) check("rand_eol_position", 32'(got_q[i].eol), 32'((i % 7) == 6));
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
      check("rand_pad_err", 32'(pad_err[2]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
